// File: rtl/sn7486_quad_xor_pkg.sv
// tt_pkg: shared TTL pin indices and a 4-state aware XOR helper.
package tt_pkg;
  localparam int VCC_PIN = 14;
  localparam int GND_PIN = 7;
  function automatic logic xor2_4s(input logic a, input logic b);
    return ((a === 1'b0 || a === 1'b1) && (b === 1'b0 || b === 1'b1)) ? a ^ b : 1'bx;
  endfunction
endpackage

// File: rtl/sn7486_quad_xor_if.sv
// sn7486_quad_xor_if: the 14 package pins; master is the board, slave is the chip.
interface sn7486_quad_xor_if;
  logic P1, P2, P3, P4, P5, P6, P7, P8, P9, P10, P11, P12, P13, P14;
  modport master (output P1, P2, P4, P5, P7, P9, P10, P12, P13, P14, input P3, P6, P8, P11);
  modport slave (input P1, P2, P4, P5, P7, P9, P10, P12, P13, P14, output P3, P6, P8, P11);
endinterface

// File: rtl/sn7486_quad_xor_gate.sv
// ttl_xor2_gate: one XOR gate, forced low without power, optionally registered.
import tt_pkg::*;
module ttl_xor2_gate #(parameter bit OUT_REG = 1'b0) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic pwr_good,
  output logic y
);
  logic d, q;
  assign d = pwr_good ? xor2_4s(a, b) : 1'b0;
  always_ff @(posedge clk)
    q <= rst ? 1'b0 : d;
  // the flop is dead logic when OUT_REG=0 and is trimmed by synthesis
  assign y = OUT_REG ? q : d;
endmodule

// File: rtl/sn7486_quad_xor.sv
// sn7486_quad_xor: 7486 quad XOR package with supply monitor and optional output registers.
import tt_pkg::*;
module sn7486_quad_xor #(parameter bit OUT_REG = 1'b0) (
  input  logic clk,
  input  logic rst,
  sn7486_quad_xor_if.slave pins,
  output logic pwr_fault
);
  logic [VCC_PIN:GND_PIN] rail;
  logic pwr_good;
  // only VCC=1 and GND=0 exactly is good; any X/Z on a rail fails the match
  assign rail = {pins.P14, {(VCC_PIN - GND_PIN - 1){1'b0}}, pins.P7};
  assign pwr_good = (rail === {1'b1, {(VCC_PIN - GND_PIN){1'b0}}});
  always_ff @(posedge clk)
    pwr_fault <= rst ? 1'b0 : (pwr_fault | ~pwr_good);
  ttl_xor2_gate #(.OUT_REG(OUT_REG)) g1 (.clk(clk), .rst(rst), .a(pins.P1),  .b(pins.P2),  .pwr_good(pwr_good), .y(pins.P3));
  ttl_xor2_gate #(.OUT_REG(OUT_REG)) g2 (.clk(clk), .rst(rst), .a(pins.P4),  .b(pins.P5),  .pwr_good(pwr_good), .y(pins.P6));
  ttl_xor2_gate #(.OUT_REG(OUT_REG)) g3 (.clk(clk), .rst(rst), .a(pins.P9),  .b(pins.P10), .pwr_good(pwr_good), .y(pins.P8));
  ttl_xor2_gate #(.OUT_REG(OUT_REG)) g4 (.clk(clk), .rst(rst), .a(pins.P12), .b(pins.P13), .pwr_good(pwr_good), .y(pins.P11));
endmodule

// File: tb/tb_sn7486_quad_xor.sv
// tb_sn7486_quad_xor: directed checks of a combinational and a registered 7486.
module tb_sn7486_quad_xor;
  logic clk = 1'b0, rst_c, rst_r, pf_c, pf_r;
  int checks = 0, errors = 0;
  sn7486_quad_xor_if cif ();
  sn7486_quad_xor_if rif ();
  sn7486_quad_xor #(.OUT_REG(1'b0)) u_comb (.clk(clk), .rst(rst_c), .pins(cif), .pwr_fault(pf_c));
  sn7486_quad_xor #(.OUT_REG(1'b1)) u_reg (.clk(clk), .rst(rst_r), .pins(rif), .pwr_fault(pf_r));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  task automatic set_c(input int g, input logic a, input logic b);
    case (g)
      1: begin cif.P1 = a;  cif.P2 = b;  end
      2: begin cif.P4 = a;  cif.P5 = b;  end
      3: begin cif.P9 = a;  cif.P10 = b; end
      default: begin cif.P13 = a; cif.P12 = b; end
    endcase
  endtask
  function automatic logic y_c(input int g);
    return g == 1 ? cif.P3 : g == 2 ? cif.P6 : g == 3 ? cif.P8 : cif.P11;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  logic [3:0] xor_tab;
  logic probe;
  initial begin
    xor_tab = 4'b0110;
    {cif.P1, cif.P2, cif.P4, cif.P5, cif.P9, cif.P10, cif.P12, cif.P13} = '0;
    {rif.P1, rif.P2, rif.P4, rif.P5, rif.P9, rif.P10, rif.P12, rif.P13} = '0;
    cif.P14 = 1'b1; cif.P7 = 1'b0; rif.P14 = 1'b1; rif.P7 = 1'b0;
    rst_c = 1'b1; rst_r = 1'b1;
    tick();
    rst_c = 1'b0; rst_r = 1'b0;
    check("reset pf_c", pf_c, 1'b0);
    check("reset pf_r", pf_r, 1'b0);
    check("reset r_P3", rif.P3, 1'b0);
    check("reset r_P6", rif.P6, 1'b0);
    check("reset r_P8", rif.P8, 1'b0);
    check("reset r_P11", rif.P11, 1'b0);
    for (int g = 1; g <= 4; g++)
      for (int c = 0; c < 4; c++) begin
        set_c(g, c[1], c[0]);
        #1 check($sformatf("truth g%0d c%0d", g, c), y_c(g), xor_tab[c]);
      end
    set_c(1, 1'b1, 1'b0);
    for (int g = 2; g <= 4; g++)
      for (int c = 0; c < 4; c++) begin
        set_c(g, c[1], c[0]);
        #1 check($sformatf("indep g%0d c%0d", g, c), cif.P3, 1'b1);
      end
    for (int g = 2; g <= 4; g++) set_c(g, 1'b1, 1'b0);
    cif.P14 = 1'b0;
    #1;
    for (int g = 1; g <= 4; g++) check($sformatf("pwrloss g%0d", g), y_c(g), 1'b0);
    check("pwrloss pf before edge", pf_c, 1'b0);
    tick();
    check("pwrloss pf", pf_c, 1'b1);
    cif.P14 = 1'b1;
    #1;
    for (int g = 1; g <= 4; g++) check($sformatf("restore g%0d", g), y_c(g), 1'b1);
    tick();
    check("pf sticky", pf_c, 1'b1);
    rst_c = 1'b1;
    tick();
    check("pf cleared", pf_c, 1'b0);
    cif.P7 = 1'b1;
    tick();
    check("pf rst wins", pf_c, 1'b0);
    check("gnd bad P3", cif.P3, 1'b0);
    rst_c = 1'b0;
    tick();
    check("pf gnd set", pf_c, 1'b1);
    cif.P7 = 1'b0;
    rst_c = 1'b1;
    tick();
    rst_c = 1'b0;
    set_c(1, 1'b0, 1'b1); set_c(2, 1'b1, 1'b1); set_c(4, 1'b1, 1'b0);
    probe = 1'bx;
    cif.P9 = 1'bx; cif.P10 = 1'b0;
    #1;
    if (probe === 1'bx) check("x P8", cif.P8, 1'bx);
    check("x P3", cif.P3, 1'b1);
    check("x P6", cif.P6, 1'b0);
    check("x P11", cif.P11, 1'b1);
    rif.P4 = 1'b0; rif.P5 = 1'b1;
    #1 check("reg P6 pre-edge", rif.P6, 1'b0);
    tick();
    check("reg P6 post-edge", rif.P6, 1'b1);
    check("reg P3 held", rif.P3, 1'b0);
    rst_r = 1'b1;
    tick();
    check("reg P6 rst", rif.P6, 1'b0);
    rst_r = 1'b0;
    tick();
    check("reg P6 resume", rif.P6, 1'b1);
    rif.P14 = 1'b0;
    tick();
    check("reg P6 pwrloss", rif.P6, 1'b0);
    check("reg pf", pf_r, 1'b1);
    rif.P14 = 1'b1;
    tick();
    check("reg P6 restore", rif.P6, 1'b1);
    check("reg pf sticky", pf_r, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
